// File: rtl/mem_access_master_team1_pkg.sv
// Shared types and constants for the memory-access master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_access_pkg_team1;

  // Master sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int DEF_DW = 16;
  localparam int DEF_AW = 12;

  // Address the memory guards; requests to it are rejected locally
  localparam int ADDR_GUARD = 0;

endpackage

// File: rtl/mem_access_master_team1_req_fifo.sv
// Generic synchronous FIFO with full/empty flags, combinational head read.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: pushes are ignored while full (even with a same-cycle pop); pops ignored while empty.
//
// Ports: clk, rst_n (async active-low, flushes pointers), push/wdata, pop/rdata,
//        full, empty.
module req_fifo_team1 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign rdata = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mem_access_master_team1.sv
// Memory bus master: queues read/write requests and drives memory strobes, one response per request.
// Latency: from accept edge E0 in IDLE, strobe/error response at E1, write response E2, read response E(1+RD_LAT).
// Backpressure: req_ready = !fifo_full; responses cannot be stalled.
//
// Ports: req_valid/req_ready/req_write/req_addr/req_wdata (request in),
//        rsp_valid/rsp_err/rsp_rdata (response out), mem_write/mem_read/mem_addr/
//        mem_wdata/mem_rdata (memory side), busy (work pending or in flight).
module mem_access_master_team1
  import mem_access_pkg_team1::*;
#(
  parameter int DW         = DEF_DW,
  parameter int AW         = DEF_AW,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_rdata,
  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int EW = 1 + AW + DW;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t        state;
  logic [CW-1:0] cnt;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] fifo_wdat;
  logic [EW-1:0] fifo_rdat;

  logic          head_write;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_wdata;

  assign fifo_push = req_valid && !fifo_full;
  assign fifo_wdat = {req_write, req_addr, req_wdata};

  // Head is consumed on the same edge the FSM dispatches it
  assign fifo_pop  = ((state == IDLE) || (state == RESP)) && !fifo_empty;

  assign head_write = fifo_rdat[EW-1];
  assign head_addr  = fifo_rdat[DW +: AW];
  assign head_wdata = fifo_rdat[DW-1:0];

  assign req_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;

  req_fifo_team1 #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdat),
    .pop   (fifo_pop),
    .rdata (fifo_rdat),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_addr  <= AW'(1);  // park off the guarded address
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (!fifo_empty) begin
            rsp_rdata <= '0;
            if (head_addr == AW'(ADDR_GUARD)) begin
              // Rejected locally: respond now, memory untouched, address held
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= RESP;
            end else if (head_write) begin
              rsp_valid <= 1'b0;
              rsp_err   <= 1'b0;
              mem_write <= 1'b1;
              mem_addr  <= head_addr;
              mem_wdata <= head_wdata;
              state     <= WR;
            end else begin
              rsp_valid <= 1'b0;
              rsp_err   <= 1'b0;
              mem_read  <= 1'b1;
              mem_addr  <= head_addr;
              cnt       <= CW'(RD_LAT - 1);
              state     <= RD;
            end
          end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        WR: begin
          mem_write <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          state     <= RESP;
        end
        RD: begin
          if (cnt == '0) begin
            mem_read  <= 1'b0;
            rsp_rdata <= mem_rdata;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_master_team1.md
Name: mem_access_master_team1

Overview:
- Bus-master (initiator) side of the 16-bit × 4096-word memory interface.
- Accepts read/write requests from the control unit or a test harness via valid/ready, buffers them in a small FIFO, and drives the memory's Write/Read strobes, address and write data.
- Captures read data and returns one response per request; rejects address 0 locally without strobing memory.
- Sits between the sequencer/datapath and the memory array.

Parameters:
- DW, 16, data word width; matches memory word size.
- AW, 12, address width.
- RD_LAT, 1, cycles mem_read is held before mem_rdata is sampled (≥1).
- FIFO_DEPTH, 2, request FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept; equals !full.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  AW  target address.
- req_wdata  in  DW  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse per completed request; no backpressure.
- rsp_err  out  1  qualifies rsp_valid; 1 = request rejected (address 0).
- rsp_rdata  out  DW  read data; 0 for writes and errors.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  state != IDLE or FIFO non-empty.

Behaviour:
- Reset, asynchronous:
  - FIFO flushed; state IDLE.
  - mem_write, mem_read, rsp_valid and rsp_err = 0; rsp_rdata and mem_wdata = 0.
  - mem_addr = 1, so the memory never idles on its guarded address 0.
  - req_ready = 1.
- Reset mid-operation drops the in-flight and queued requests with no response. Strobes fall immediately.
- FIFO:
  - Push on req_valid && req_ready.
  - No push while full, even if a pop occurs the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Entry holds {write, addr, wdata}.
- FSM states: IDLE, WR, RD, RESP. All outputs are registered.
- Dispatch, evaluated in IDLE and RESP when the FIFO is non-empty:
  - Pop the head.
  - addr == 0: rsp_valid = 1, rsp_err = 1, no strobe; go to RESP.
  - Write: mem_write = 1, load mem_addr and mem_wdata; go to WR.
  - Read: mem_read = 1, load mem_addr, cnt = RD_LAT-1; go to RD.
- IDLE with FIFO empty: stay. mem_addr and mem_wdata hold their last values.
- WR (one cycle): mem_write = 0; rsp_valid = 1, rsp_err = 0, rsp_rdata = 0; go to RESP.
- RD:
  - If cnt == 0: rsp_rdata = mem_rdata, mem_read = 0, rsp_valid = 1; go to RESP.
  - Otherwise decrement cnt.
- RESP:
  - If the FIFO is empty: rsp_valid = 0, rsp_err = 0; go to IDLE.
  - Otherwise apply dispatch. A consecutive rsp_valid cycle means a distinct response.
- Latency, measured from the accept edge E0 with the FSM in IDLE:
  - Strobe rises at E1.
  - Error response at E1.
  - Write response at E2.
  - Read response at E(1+RD_LAT).
- Throughput: back-to-back writes give one response every 2 cycles; reads every RD_LAT+1 cycles.
- Invariants:
  - mem_write and mem_read are never both 1.
  - mem_addr and mem_wdata are stable while a strobe is high.
  - Responses are returned in request order.

Decomposition:
- Package mem_access_pkg_team1 holds:
  - State enum {IDLE, WR, RD, RESP}.
  - Default widths DW = 16, AW = 12.
  - Constant ADDR_GUARD = 0.
- Sub-module req_fifo_team1: parameterised synchronous FIFO with full/empty flags and async active-low reset. The FSM and output registers stay in the top.

Test Plan:
- Write 0x1234 to 0x005, then read 0x005 (RD_LAT = 1):
  - mem_write high exactly 1 cycle with mem_addr = 0x005.
  - Write response at E2.
  - Read response rsp_rdata = 0x1234 at E(1+RD_LAT) after its accept edge.
- Request to addr 0x000, read and write: rsp_valid = 1, rsp_err = 1 at E1; mem_read and mem_write stay 0.
- Hold req_valid with 4 writes to 0x010–0x013 (FIFO_DEPTH = 2):
  - req_ready drops when full.
  - All 4 accepted eventually; 4 in-order responses, each 2 cycles apart.
- RD_LAT = 3 build, read 0x0FF preloaded 0xBEEF: mem_read high 3 cycles; rsp_rdata = 0xBEEF; busy falls 1 cycle after rsp_valid.
- Assert rst_n = 0 while in RD with 1 queued request:
  - Outputs return to reset values asynchronously; mem_addr = 0x001.
  - No response after reset release; req_ready = 1.
- Random mix of 200 requests checked against a scoreboard memory model: order, data and err all match; mem_write and mem_read never both high.
